// File: rtl/bk_sequencer.sv
// Backup-RAM sector sequencer: streams every sector of one save slot between the
// SD image (hps_io block interface) and system backup RAM, with ack timeout and autosave.
module bk_sequencer #(
  parameter int unsigned SLOT_BITS  = 2,
  parameter int unsigned SECT_BITS  = 6,
  parameter int unsigned TMO_BITS   = 20,
  parameter int unsigned AUTOSAVE   = 0,
  parameter int unsigned QUIET_BITS = 24
) (
  input  logic                 clk_sys,
  input  logic                 RESET_n,
  input  logic                 downloading,
  input  logic                 img_mounted,
  input  logic                 img_readonly,
  input  logic                 img_size_nz,
  input  logic                 load_req,
  input  logic                 save_req,
  input  logic [SLOT_BITS-1:0] slot,
  input  logic                 dirty,
  input  logic                 sd_ack,
  output logic [31:0]          sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  output logic                 bk_ena,
  output logic                 bk_loading,
  output logic                 bk_busy,
  output logic                 bk_done,
  output logic                 bk_err
);

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StDone} state_e;

  state_e                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [31:0]           lba_q, lba_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic                  loading_q, loading_d, busy_q, busy_d;
  logic                  done_q, done_d, err_q, err_d;
  logic [TMO_BITS-1:0]   tmo_q, tmo_d;
  logic                  dirty_q, dirty_d;
  logic [QUIET_BITS-1:0] quiet_q, quiet_d;
  logic                  ena_q, ena_d;
  logic                  dl_q, dl_d, ld_q, ld_d, sv_q, sv_d, ack_q, ack_d;

  logic load_edge, save_edge, ack_rise, ack_fall, fire;

  assign load_edge = load_req & ena_q & ~ld_q;
  assign save_edge = save_req & ena_q & ~sv_q;
  assign ack_rise  = sd_ack & ~ack_q;
  assign ack_fall  = ~sd_ack & ack_q;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    lba_d     = lba_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    loading_d = loading_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tmo_d     = tmo_q;
    dirty_d   = dirty_q;
    quiet_d   = quiet_q;
    fire      = 1'b0;
    dl_d      = downloading;
    ld_d      = load_req & ena_q;
    sv_d      = save_req & ena_q;
    ack_d     = sd_ack;

    // Mount during download wins over the download-start clear.
    if (downloading && img_mounted && img_size_nz && !img_readonly) begin
      ena_d = 1'b1;
    end else if (downloading && !dl_q) begin
      ena_d = 1'b0;
    end else begin
      ena_d = ena_q;
    end

    if (AUTOSAVE != 0) begin
      if (dirty) begin
        dirty_d = 1'b1;
        quiet_d = '0;
      end else if (state_q == StIdle && dirty_q && ena_q && !downloading) begin
        if (quiet_q == '1) begin
          fire    = 1'b1;
          quiet_d = '0;
        end else begin
          quiet_d = quiet_q + 1'b1;
        end
      end
    end else begin
      dirty_d = 1'b0;
      quiet_d = '0;
    end

    unique case (state_q)
      StIdle: begin
        if (load_edge || save_edge || fire) begin
          dir_d     = load_edge;
          lba_d     = 32'(slot) << SECT_BITS;
          rd_d      = load_edge;
          wr_d      = ~load_edge;
          loading_d = load_edge;
          busy_d    = 1'b1;
          tmo_d     = '0;
          state_d   = StReq;
        end
      end
      StReq: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = StXfer;
        end else if (tmo_q == '1) begin
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          loading_d = 1'b0;
          busy_d    = 1'b0;
          err_d     = 1'b1;
          state_d   = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StXfer: begin
        if (ack_fall) begin
          if (lba_q[SECT_BITS-1:0] == '1) begin
            state_d = StDone;
          end else begin
            // Sector field wraps on its own; the slot field is never touched.
            lba_d   = {lba_q[31:SECT_BITS], lba_q[SECT_BITS-1:0] + SECT_BITS'(1)};
            rd_d    = dir_q;
            wr_d    = ~dir_q;
            tmo_d   = '0;
            state_d = StReq;
          end
        end
      end
      StDone: begin
        done_d    = 1'b1;
        loading_d = 1'b0;
        busy_d    = 1'b0;
        dirty_d   = (AUTOSAVE != 0) && dirty;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= StIdle;
      dir_q     <= 1'b0;
      lba_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      loading_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
      dirty_q   <= 1'b0;
      quiet_q   <= '0;
      ena_q     <= 1'b0;
      dl_q      <= 1'b0;
      ld_q      <= 1'b0;
      sv_q      <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      lba_q     <= lba_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      loading_q <= loading_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      dirty_q   <= dirty_d;
      quiet_q   <= quiet_d;
      ena_q     <= ena_d;
      dl_q      <= dl_d;
      ld_q      <= ld_d;
      sv_q      <= sv_d;
      ack_q     <= ack_d;
    end
  end

  assign sd_lba     = lba_q;
  assign sd_rd      = rd_q;
  assign sd_wr      = wr_q;
  assign bk_ena     = ena_q;
  assign bk_loading = loading_q;
  assign bk_busy    = busy_q;
  assign bk_done    = done_q;
  assign bk_err     = err_q;

endmodule

// File: tb/tb_bk_sequencer.sv
// Scoreboard bench for bk_sequencer: expected sector addresses are queued when a
// request level is raised and popped as the DUT issues each sd_rd/sd_wr.
module tb_bk_sequencer;

  logic        clk_sys = 1'b0;
  logic        RESET_n = 1'b0;
  logic        downloading = 1'b0, img_mounted = 1'b0, img_readonly = 1'b0, img_size_nz = 1'b0;
  logic        load_req = 1'b0, save_req = 1'b0, dirty = 1'b0, sd_ack = 1'b0;
  logic [1:0]  slot = 2'd0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, bk_done, bk_err;

  int vecs = 0;
  int errs = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_q[$];

  bk_sequencer #(
    .SLOT_BITS (2),
    .SECT_BITS (6),
    .TMO_BITS  (4),
    .AUTOSAVE  (1),
    .QUIET_BITS(4)
  ) dut (
    .clk_sys     (clk_sys),
    .RESET_n     (RESET_n),
    .downloading (downloading),
    .img_mounted (img_mounted),
    .img_readonly(img_readonly),
    .img_size_nz (img_size_nz),
    .load_req    (load_req),
    .save_req    (save_req),
    .slot        (slot),
    .dirty       (dirty),
    .sd_ack      (sd_ack),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .bk_ena      (bk_ena),
    .bk_loading  (bk_loading),
    .bk_busy     (bk_busy),
    .bk_done     (bk_done),
    .bk_err      (bk_err)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (bk_done) done_cnt++;
    if (bk_err)  err_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus only: ack 3 cycles after a request is seen, hold it 4 cycles.
  task automatic ack_one();
    repeat (3) @(negedge clk_sys);
    sd_ack = 1'b1;
    repeat (4) @(negedge clk_sys);
    sd_ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_sys);
    vecs++;
    if ({sd_lba, sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, bk_done, bk_err} !== 39'd0) begin
      errs++;
      $display("FAIL reset_outputs: got lba=%0d rd=%b wr=%b ena=%b ld=%b busy=%b, required all 0",
               sd_lba, sd_rd, sd_wr, bk_ena, bk_loading, bk_busy);
    end
    RESET_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    vecs++;
    if (bk_busy !== 1'b0 || bk_ena !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: got busy=%b ena=%b, required 0 0", bk_busy, bk_ena);
    end
  endtask

  task automatic test_bk_ena();
    downloading = 1'b1; img_size_nz = 1'b1; img_readonly = 1'b1;
    @(negedge clk_sys); img_mounted = 1'b1;
    @(negedge clk_sys); img_mounted = 1'b0;
    vecs++;
    if (bk_ena !== 1'b0) begin
      errs++; $display("FAIL ena_readonly: got %b, required 0", bk_ena);
    end
    img_readonly = 1'b0; img_mounted = 1'b1;
    @(negedge clk_sys); img_mounted = 1'b0;
    vecs++;
    if (bk_ena !== 1'b1) begin
      errs++; $display("FAIL ena_mount: got %b, required 1", bk_ena);
    end
    downloading = 1'b0;
    @(negedge clk_sys); downloading = 1'b1;
    @(negedge clk_sys);
    vecs++;
    if (bk_ena !== 1'b0) begin
      errs++; $display("FAIL ena_dl_clear: got %b, required 0", bk_ena);
    end
    downloading = 1'b0;
    @(negedge clk_sys); downloading = 1'b1; img_mounted = 1'b1;
    @(negedge clk_sys); img_mounted = 1'b0; downloading = 1'b0;
    vecs++;
    if (bk_ena !== 1'b1) begin
      errs++; $display("FAIL ena_set_wins: got %b, required 1", bk_ena);
    end
    @(negedge clk_sys);
  endtask

  task automatic test_save();
    int w;
    int d0;
    int e0;
    logic [31:0] exp;
    d0 = done_cnt; e0 = err_cnt;
    slot = 2'd2;
    for (int i = 0; i < 64; i++) exp_q.push_back(32'(128 + i));
    save_req = 1'b1;
    for (int k = 0; k < 64; k++) begin
      w = 0;
      while (!(sd_rd || sd_wr) && w < 20) begin @(negedge clk_sys); w++; end
      vecs++;
      if (w >= 20) begin
        errs++; $display("FAIL save_wait: k=%0d no request in 20 cycles, required sd_wr", k);
      end
      exp = exp_q.pop_front();
      vecs++;
      if (sd_lba !== exp) begin
        errs++; $display("FAIL save_lba: k=%0d got %0d, required %0d", k, sd_lba, exp);
      end
      vecs++;
      if (sd_wr !== 1'b1 || sd_rd !== 1'b0 || bk_loading !== 1'b0) begin
        errs++;
        $display("FAIL save_dir: k=%0d got wr=%b rd=%b loading=%b, required 1 0 0",
                 k, sd_wr, sd_rd, bk_loading);
      end
      ack_one();
    end
    repeat (10) @(negedge clk_sys);
    vecs++;
    if (done_cnt - d0 != 1 || err_cnt != e0) begin
      errs++;
      $display("FAIL save_done: got done=%0d err=%0d, required 1 0", done_cnt - d0, err_cnt - e0);
    end
    vecs++;
    if (bk_busy !== 1'b0 || sd_wr !== 1'b0) begin
      errs++; $display("FAIL save_idle: got busy=%b wr=%b, required 0 0", bk_busy, sd_wr);
    end
    save_req = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_load_priority();
    int w;
    int d0;
    logic [31:0] exp;
    d0 = done_cnt;
    slot = 2'd3;
    for (int i = 0; i < 64; i++) exp_q.push_back(32'(192 + i));
    load_req = 1'b1; save_req = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (k == 5) begin load_req = 1'b0; save_req = 1'b0; end
      if (k == 8) save_req = 1'b1;
      if (k == 9) load_req = 1'b1;
      w = 0;
      while (!(sd_rd || sd_wr) && w < 20) begin @(negedge clk_sys); w++; end
      vecs++;
      if (w >= 20) begin
        errs++; $display("FAIL load_wait: k=%0d no request in 20 cycles, required sd_rd", k);
      end
      exp = exp_q.pop_front();
      vecs++;
      if (sd_lba !== exp) begin
        errs++; $display("FAIL load_lba: k=%0d got %0d, required %0d", k, sd_lba, exp);
      end
      vecs++;
      if (sd_rd !== 1'b1 || sd_wr !== 1'b0 || bk_loading !== 1'b1) begin
        errs++;
        $display("FAIL load_dir: k=%0d got rd=%b wr=%b loading=%b, required 1 0 1",
                 k, sd_rd, sd_wr, bk_loading);
      end
      ack_one();
    end
    repeat (12) @(negedge clk_sys);
    vecs++;
    if (done_cnt - d0 != 1) begin
      errs++; $display("FAIL load_done: got %0d pulses, required 1", done_cnt - d0);
    end
    vecs++;
    if (bk_loading !== 1'b0 || bk_busy !== 1'b0 || sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
      errs++;
      $display("FAIL load_dropped_edge: got loading=%b busy=%b rd=%b wr=%b, required 0 0 0 0",
               bk_loading, bk_busy, sd_rd, sd_wr);
    end
    load_req = 1'b0; save_req = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_timeout();
    int w;
    int n;
    int d0;
    int e0;
    d0 = done_cnt; e0 = err_cnt;
    slot = 2'd0;
    load_req = 1'b1;
    w = 0;
    while (!sd_rd && w < 20) begin @(negedge clk_sys); w++; end
    vecs++;
    if (w >= 20 || sd_lba !== 32'd0) begin
      errs++; $display("FAIL tmo_start: got rd=%b lba=%0d, required 1 0", sd_rd, sd_lba);
    end
    n = 0;
    while (sd_rd && n < 40) begin n++; @(negedge clk_sys); end
    vecs++;
    if (n < 15 || n > 17) begin
      errs++; $display("FAIL tmo_length: rd held %0d cycles, required 15..17", n);
    end
    vecs++;
    if (bk_err !== 1'b1 || bk_busy !== 1'b0 || bk_loading !== 1'b0) begin
      errs++;
      $display("FAIL tmo_abort: got err=%b busy=%b loading=%b, required 1 0 0",
               bk_err, bk_busy, bk_loading);
    end
    @(negedge clk_sys);
    vecs++;
    if (bk_err !== 1'b0) begin
      errs++; $display("FAIL tmo_pulse: bk_err got %b one cycle later, required 0", bk_err);
    end
    repeat (5) @(negedge clk_sys);
    vecs++;
    if (err_cnt - e0 != 1 || done_cnt != d0) begin
      errs++;
      $display("FAIL tmo_counts: got err=%0d done=%0d, required 1 0", err_cnt - e0, done_cnt - d0);
    end
    load_req = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_autosave();
    int w;
    int c;
    int d0;
    logic [31:0] exp;
    d0 = done_cnt;
    slot = 2'd1;
    for (int i = 0; i < 64; i++) exp_q.push_back(32'(64 + i));
    dirty = 1'b1;
    @(negedge clk_sys); dirty = 1'b0;
    repeat (4) @(negedge clk_sys);
    dirty = 1'b1;
    @(negedge clk_sys); dirty = 1'b0;
    c = 0;
    while (!(sd_rd || sd_wr) && c < 40) begin @(negedge clk_sys); c++; end
    vecs++;
    if (c < 14 || c > 18) begin
      errs++; $display("FAIL auto_quiet: save after %0d cycles, required 14..18", c);
    end
    for (int k = 0; k < 64; k++) begin
      w = 0;
      while (!(sd_rd || sd_wr) && w < 20) begin @(negedge clk_sys); w++; end
      exp = exp_q.pop_front();
      vecs++;
      if (w >= 20 || sd_lba !== exp || sd_wr !== 1'b1 || sd_rd !== 1'b0) begin
        errs++;
        $display("FAIL auto_req: k=%0d got lba=%0d wr=%b rd=%b, required lba=%0d wr=1 rd=0",
                 k, sd_lba, sd_wr, sd_rd, exp);
      end
      ack_one();
    end
    repeat (10) @(negedge clk_sys);
    vecs++;
    if (done_cnt - d0 != 1) begin
      errs++; $display("FAIL auto_done: got %0d pulses, required 1", done_cnt - d0);
    end
    c = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr) c++;
    end
    vecs++;
    if (c != 0) begin
      errs++; $display("FAIL auto_flag_clear: request seen %0d cycles after save, required 0", c);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int w;
    int d0;
    int e0;
    logic [31:0] exp;
    d0 = done_cnt; e0 = err_cnt;
    slot = 2'd1;
    for (int i = 0; i < 7; i++) exp_q.push_back(32'(64 + i));
    save_req = 1'b1;
    for (int k = 0; k < 7; k++) begin
      w = 0;
      while (!(sd_rd || sd_wr) && w < 20) begin @(negedge clk_sys); w++; end
      exp = exp_q.pop_front();
      vecs++;
      if (w >= 20 || sd_lba !== exp) begin
        errs++; $display("FAIL rst_lba: k=%0d got %0d, required %0d", k, sd_lba, exp);
      end
      if (k < 6) ack_one();
    end
    repeat (3) @(negedge clk_sys);
    sd_ack = 1'b1;
    repeat (2) @(negedge clk_sys);
    RESET_n = 1'b0;
    #1;
    vecs++;
    if (sd_lba !== 32'd0 || sd_rd !== 1'b0 || sd_wr !== 1'b0 || bk_busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_async: got lba=%0d rd=%b wr=%b busy=%b, required 0 0 0 0",
               sd_lba, sd_rd, sd_wr, bk_busy);
    end
    sd_ack = 1'b0;
    @(negedge clk_sys);
    RESET_n = 1'b1;
    repeat (20) @(negedge clk_sys);
    vecs++;
    if (done_cnt != d0 || err_cnt != e0 || bk_busy !== 1'b0 || sd_rd !== 1'b0 || sd_wr !== 1'b0)
    begin
      errs++;
      $display("FAIL rst_after: got done=%0d err=%0d busy=%b, required 0 0 0",
               done_cnt - d0, err_cnt - e0, bk_busy);
    end
    save_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bk_ena();
    test_save();
    test_load_priority();
    test_timeout();
    test_autosave();
    test_reset_mid_xfer();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/bk_sequencer.md
Name: bk_sequencer

Overview:
- Parametrised save-state/backup-RAM sector sequencer between hps_io SD block interface and the system backup RAM port.
- Manages a slot count and slot size set by parameters. Streams all sectors of the chosen slot to or from the SD image.
- Adds ack timeout with error reporting, and optional autosave after dirty-RAM quiet time.
- Sits in emu top level. Drives sd_lba/sd_rd/sd_wr; supplies bk_loading to the reset tree.

Parameters:
- SLOT_BITS, 2, log2 of slot count; slot index forms sd_lba[SLOT_BITS+SECT_BITS-1:SECT_BITS].
- SECT_BITS, 6, log2 of 512-byte sectors per slot (64 sectors = 32 KB).
- TMO_BITS, 20, width of ack-timeout counter; timeout at all-ones.
- AUTOSAVE, 0, 1 enables autosave to the current slot.
- QUIET_BITS, 24, width of autosave quiet counter; autosave fires at all-ones.

Ports:
- clk_sys  in  1  system clock
- RESET_n  in  1  async active-low reset
- downloading  in  1  ROM download in progress
- img_mounted  in  1  image-mounted pulse from hps_io
- img_readonly  in  1  mounted image is read-only
- img_size_nz  in  1  mounted image size nonzero
- load_req  in  1  load request level (status bit)
- save_req  in  1  save request level (status bit)
- slot  in  SLOT_BITS  slot select, sampled at start
- dirty  in  1  backup RAM write strobe from system
- sd_ack  in  1  hps_io transfer acknowledge
- sd_lba  out  32  sector address
- sd_rd  out  1  read request
- sd_wr  out  1  write request
- bk_ena  out  1  save file usable; gates menu entries
- bk_loading  out  1  load in progress (held in system reset)
- bk_busy  out  1  any transfer in progress (LED)
- bk_done  out  1  one-cycle pulse, slot transfer completed
- bk_err  out  1  one-cycle pulse, transfer aborted on timeout

Behaviour:
- Async reset: all outputs 0, sd_lba=0, FSM IDLE, counters 0, dirty flag 0, edge registers 0.
- bk_ena: cleared on rising edge of downloading. Set when downloading & img_mounted & img_size_nz & ~img_readonly. Set wins if both occur in the same cycle.
- Request edges: rising edges of load_req&bk_ena and save_req&bk_ena are registered. Edge registers update every cycle, even while busy.
- Edges arriving while busy are dropped, not queued.
- Simultaneous load and save edges: load wins.
- FSM states: IDLE, REQ, XFER, DONE.
- IDLE→REQ on accepted edge, or on autosave fire:
  - latch dir (load=1);
  - sd_lba={slot,SECT_BITS'0}, upper bits 0;
  - sd_rd=dir, sd_wr=~dir;
  - bk_loading=dir, bk_busy=1;
  - timeout counter cleared.
- REQ: rising edge of sd_ack clears sd_rd/sd_wr and moves to XFER. The timeout counter runs each cycle. At all-ones: clear rd/wr, bk_loading, bk_busy; pulse bk_err; go IDLE.
- XFER: falling edge of sd_ack.
  - If sd_lba[SECT_BITS-1:0] is all ones, go DONE.
  - Otherwise increment sd_lba, reassert sd_rd=dir / sd_wr=~dir, clear timeout, go REQ.
  - Increment never carries into the slot field.
  - No timeout in XFER; hps_io always ends the ack.
- DONE: pulse bk_done one cycle; clear bk_loading, bk_busy, dirty flag; go IDLE.
- sd_rd and sd_wr are never both 1.
- Autosave (AUTOSAVE=1 only; otherwise dirty ignored and counter held at 0):
  - dirty sets the dirty flag and clears the quiet counter.
  - In IDLE with flag set, bk_ena=1 and ~downloading, the quiet counter increments. At all-ones it triggers a save to the current slot.
  - A manual request in the same cycle wins.
  - A completed save clears the flag. An aborted save leaves it set, so the next quiet period retries.
  - A load completion also clears the flag.
- Reset mid-transfer: everything returns to reset values immediately; no completion or error pulse.

Test Plan:
- Mount writable image during download (img_size_nz=1, readonly=0) → bk_ena=1. New download rising edge → bk_ena=0.
- bk_ena=1, slot=2, save_req 0→1; bench acks each request 3 cycles later for 4 cycles:
  - sd_wr with sd_lba stepping 128..191, 64 requests;
  - bk_done once after the last ack falls;
  - bk_loading=0 throughout.
- slot=3, load_req and save_req both rise the same cycle:
  - sd_rd only, sd_lba starts 192;
  - bk_loading=1 until bk_done;
  - second edge during transfer ignored.
- Load with sd_ack never asserted, TMO_BITS=4 → after 15 cycles in REQ: sd_rd=0, bk_err pulse, bk_busy=0, bk_loading=0.
- AUTOSAVE=1, QUIET_BITS=4, slot=1, one dirty pulse:
  - save starts at lba 64 after the quiet period;
  - another dirty pulse 5 cycles after the first restarts the count.
- Drop RESET_n mid-XFER at lba 70 → sd_lba=0, sd_rd=sd_wr=0, bk_busy=0, no bk_done or bk_err after release.
